// File: rtl/adder_arbiter.sv
// ---------------------------------------------------------------------------
// adder_arbiter
//   Two requesters share one 8-bit parallel_adder. A combinational
//   round-robin arbiter picks which requester feeds the adder. The 9-bit
//   sum and the winner's index go into a single result register, which
//   drains through a valid/ready handshake.
//
// Parameters
//   FIRST_PRIO   requester index (0 or 1) that wins the first tie after reset
//
// Ports
//   clk_i                      rising-edge clock
//   rst_i                      asynchronous active-high reset
//   req0_valid_i/a_i/b_i       requester 0 operand pair and valid
//   req0_ready_o               requester 0 transfer accepted this cycle
//   req1_valid_i/a_i/b_i       requester 1 operand pair and valid
//   req1_ready_o               requester 1 transfer accepted this cycle
//   res_valid_o                result register holds a valid sum
//   res_data_o                 9-bit unsigned sum (bit 8 = carry out)
//   res_id_o                   requester that produced res_data_o
//   res_ready_i                consumer accepts the result
//   gnt0_cnt_o, gnt1_cnt_o     saturating per-requester transfer counters,
//                              present only when ADDER_ARB_STATS_EN is defined
//
// Build option
//   ADDER_ARB_STATS_EN         adds the transfer counters and their ports
// ---------------------------------------------------------------------------

// parallel_adder: 8-bit adder with carry in/out; the one shared datapath
module parallel_adder (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       cin_i,
  output logic [7:0] sum_o,
  output logic       cout_o
);

  // Zero-extend both operands so the carry lands in the ninth bit.
  always_comb begin
    {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {8'd0, cin_i};
  end

endmodule

module adder_arbiter #(
  parameter int FIRST_PRIO = 0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req0_valid_i,
  input  logic [7:0] req0_a_i,
  input  logic [7:0] req0_b_i,
  output logic       req0_ready_o,
  input  logic       req1_valid_i,
  input  logic [7:0] req1_a_i,
  input  logic [7:0] req1_b_i,
  output logic       req1_ready_o,
  output logic       res_valid_o,
  output logic [8:0] res_data_o,
  output logic       res_id_o,
  input  logic       res_ready_i
`ifdef ADDER_ARB_STATS_EN
  ,
  output logic [15:0] gnt0_cnt_o,
  output logic [15:0] gnt1_cnt_o
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  // Reset lastGrant to the requester that should lose the first tie.
  // FIRST_PRIO then wins that tie.
  localparam logic RESET_LAST = (FIRST_PRIO == 0) ? 1'b1 : 1'b0;

  state_e     state_q, state_d;
  logic       lastGrant_q;
  logic [8:0] resData_q;
  logic       resId_q;

  logic       grantValid;
  logic       grantId;
  logic       canAccept;
  logic       transfer;
  logic [7:0] opA;
  logic [7:0] opB;
  logic [7:0] sum;
  logic       carry;

  // Arbitration: a lone valid requester always wins. On a tie, the
  // requester that did not win the last real transfer is chosen.
  always_comb begin
    grantValid = 1'b0;
    grantId    = 1'b0;
    if (req0_valid_i && req1_valid_i) begin
      grantValid = 1'b1;
      grantId    = ~lastGrant_q;
    end else if (req0_valid_i) begin
      grantValid = 1'b1;
      grantId    = 1'b0;
    end else if (req1_valid_i) begin
      grantValid = 1'b1;
      grantId    = 1'b1;
    end
  end

  // The result slot can take a new sum if it is empty, or if the consumer
  // drains it in this same cycle. Reset blocks any acceptance, so both
  // ready outputs stay low while rst_i is high.
  always_comb begin
    canAccept    = !rst_i && ((state_q == EMPTY) || res_ready_i);
    transfer     = grantValid && canAccept;
    req0_ready_o = transfer && (grantId == 1'b0);
    req1_ready_o = transfer && (grantId == 1'b1);
  end

  // Select the adder operands from the granted requester. Carry-in is
  // tied low.
  always_comb begin
    opA = grantId ? req1_a_i : req0_a_i;
    opB = grantId ? req1_b_i : req0_b_i;
  end

  parallel_adder u_adder (
    .a_i    (opA),
    .b_i    (opB),
    .cin_i  (1'b0),
    .sum_o  (sum),
    .cout_o (carry)
  );

  // Next-state logic for the result slot. A transfer always leaves it full.
  // A drain with no refill empties it. Otherwise it holds.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: begin
        if (transfer) state_d = FULL;
      end
      FULL: begin
        if (transfer)         state_d = FULL;
        else if (res_ready_i) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  // State register. Reset discards any held result at once, with no
  // handshake.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  // Result, winner index and round-robin pointer change only on a real
  // transfer. The held result stays stable while the consumer stalls.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      resData_q   <= 9'd0;
      resId_q     <= 1'b0;
      lastGrant_q <= RESET_LAST;
    end else if (transfer) begin
      resData_q   <= {carry, sum};
      resId_q     <= grantId;
      lastGrant_q <= grantId;
    end
  end

  assign res_valid_o = (state_q == FULL);
  assign res_data_o  = resData_q;
  assign res_id_o    = resId_q;

`ifdef ADDER_ARB_STATS_EN
  logic [15:0] gnt0Cnt_q;
  logic [15:0] gnt1Cnt_q;

  // Per-requester transfer counters. Each one sticks at all-ones instead
  // of wrapping.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gnt0Cnt_q <= 16'd0;
      gnt1Cnt_q <= 16'd0;
    end else begin
      if (req0_ready_o && (gnt0Cnt_q != 16'hFFFF)) gnt0Cnt_q <= gnt0Cnt_q + 16'd1;
      if (req1_ready_o && (gnt1Cnt_q != 16'hFFFF)) gnt1Cnt_q <= gnt1Cnt_q + 16'd1;
    end
  end

  assign gnt0_cnt_o = gnt0Cnt_q;
  assign gnt1_cnt_o = gnt1Cnt_q;
`endif

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter: FIRST_PRIO, default 0, requester index (0 or 1) that wins the first tie after reset.
REQ-002 Port: clk_i  input  1  single clock, all state updates on rising edge.
REQ-003 Port: rst_i  input  1  asynchronous, active-high reset.
REQ-004 Port: req0_valid_i  input  1  requester 0 has an operand pair.
REQ-005 Port: req0_a_i, req0_b_i  input  8 each  requester 0 operands.
REQ-006 Port: req0_ready_o  output  1  requester 0 transfer accepted this cycle.
REQ-007 Port: req1_valid_i, req1_a_i, req1_b_i, req1_ready_o  as REQ-004..006 for requester 1.
REQ-008 Port: res_valid_o  output  1  result register holds a valid sum.
REQ-009 Port: res_data_o  output  9  unsigned sum, bit 8 = carry out.
REQ-010 Port: res_id_o  output  1  index of the requester that produced res_data_o.
REQ-011 Port: res_ready_i  input  1  consumer accepts the result.

Function
REQ-012 The block SHALL share exactly one instance of the team's 8-bit parallel_adder (carry-in tied 0) between both requesters.
REQ-013 A transfer on requester N SHALL occur when reqN_valid_i and reqN_ready_o are both high at a rising edge; requesters SHALL hold valid and operands stable until ready.
REQ-014 can_accept SHALL be high when res_valid_o is low, or when res_valid_o and res_ready_i are both high (same-cycle drain and refill).
REQ-015 Arbitration SHALL be combinational: only one valid -> that requester granted; both valid -> requester other than last_grant granted; neither -> no grant.
REQ-016 reqN_ready_o SHALL equal (grant == N) AND can_accept; at most one ready SHALL be high in any cycle; ready SHALL never be high for an invalid requester.
REQ-017 The adder inputs SHALL be muxed from the granted requester; on transfer, sum and granted index SHALL be registered into res_data_o/res_id_o and res_valid_o set the next cycle (latency 1 cycle, throughput 1 per cycle).
REQ-018 last_grant SHALL update to the granted index only on an actual transfer.
REQ-019 FSM states: EMPTY (res_valid_o=0), FULL (res_valid_o=1). EMPTY->FULL on transfer; FULL->EMPTY on res_ready_i with no transfer; FULL->FULL on drain+transfer or stall.
REQ-020 In FULL with res_ready_i low, res_data_o and res_id_o SHALL remain stable and both ready outputs SHALL be low.
REQ-021 Sum width: 9 bits, no truncation; 8'hFF + 8'hFF SHALL yield 9'h1FE.

Reset
REQ-022 rst_i high SHALL immediately force res_valid_o=0, res_data_o=0, res_id_o=0, state EMPTY, last_grant = 1-FIRST_PRIO, independent of clk_i.
REQ-023 Ready outputs SHALL be low while rst_i is high.
REQ-024 Reset during FULL SHALL discard the held result without handshake; the first transfer after release SHALL follow REQ-015.

Configuration
REQ-025 Macro ADDER_ARB_STATS_EN: when defined, the block SHALL add outputs gnt0_cnt_o and gnt1_cnt_o (16 bits each) counting transfers per requester, saturating at 16'hFFFF, cleared by rst_i.
REQ-026 When ADDER_ARB_STATS_EN is undefined, the counter ports and logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-027 Single requester: req0 a=8'h12 b=8'h34, res_ready_i=1 -> next cycle res_valid_o=1, res_data_o=9'h046, res_id_o=0.
REQ-028 Carry: req1 a=8'hFF b=8'h01 -> res_data_o=9'h100, res_id_o=1.
REQ-029 Contention: both valid continuously, res_ready_i=1, FIRST_PRIO=0 -> res_id_o sequence 0,1,0,1; one result per cycle.
REQ-030 Backpressure: result held, res_ready_i=0 for 3 cycles -> res_data_o stable, both ready low; res_ready_i=1 -> drain and new transfer same cycle.
REQ-031 Reset while FULL: assert rst_i mid-cycle -> res_valid_o falls without clock edge; after release, both valid -> requester FIRST_PRIO granted first.
REQ-032 With ADDER_ARB_STATS_EN: 5 transfers from req0, 3 from req1 -> gnt0_cnt_o=5, gnt1_cnt_o=3.
